// File: rtl/im_fetch_ctrl.sv
// Instruction-memory port arbiter: a program loader streams words in during LOAD,
// the CPU fetch path reads combinationally during RUN, bad PCs park the core in FAULT.
module im_fetch_ctrl #(
    parameter int AW            = 10,
    parameter bit LOAD_ON_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   pc,
    output logic [31:0]   instr,
    output logic          cpu_stall,
    output logic          fetch_fault,
    input  logic          ld_start,
    input  logic [AW-1:0] ld_base,
    input  logic          ld_valid,
    input  logic [31:0]   ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic          ld_err,
    output logic [AW-1:0] im_addr,
    output logic          im_we,
    output logic [31:0]   im_wdata,
    input  logic [31:0]   im_dout
);

    typedef enum logic [1:0] {S_LOAD, S_RUN, S_FAULT} state_t;

    localparam state_t RST_STATE = LOAD_ON_RESET ? S_LOAD : S_RUN;

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_ptr, w_ptr_nxt;
    logic          r_ld_err, w_ld_err_nxt;
    logic          w_pc_bad;

    assign w_pc_bad = (pc[1:0] != 2'b00) || (pc[31:AW+2] != '0);
    assign ld_err   = r_ld_err;

    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_ld_err_nxt = r_ld_err;
        instr        = 32'h0;
        cpu_stall    = 1'b1;
        fetch_fault  = 1'b0;
        ld_ready     = 1'b0;
        im_addr      = '0;
        im_we        = 1'b0;
        im_wdata     = 32'h0;
        case (r_state)
            S_LOAD: begin
                // rst gates the strobes so an in-flight word is dropped at once
                ld_ready = !rst;
                im_addr  = r_ptr;
                im_we    = ld_valid && !rst;
                im_wdata = ld_valid ? ld_data : 32'h0;
                if (ld_valid) begin
                    w_ptr_nxt = r_ptr + 1'b1;
                    if (ld_last)
                        w_state_nxt = S_RUN;
                    else if (r_ptr == '1)
                        w_ld_err_nxt = 1'b1;
                end
            end
            S_RUN: begin
                cpu_stall = w_pc_bad;
                im_addr   = pc[AW+1:2];
                instr     = w_pc_bad ? 32'h0 : im_dout;
                if (ld_start) begin
                    w_state_nxt  = S_LOAD;
                    w_ptr_nxt    = ld_base;
                    w_ld_err_nxt = 1'b0;
                end else if (w_pc_bad) begin
                    w_state_nxt = S_FAULT;
                end
            end
            S_FAULT: begin
                fetch_fault = 1'b1;
                if (ld_start) begin
                    w_state_nxt  = S_LOAD;
                    w_ptr_nxt    = ld_base;
                    w_ld_err_nxt = 1'b0;
                end
            end
            default: w_state_nxt = RST_STATE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= RST_STATE;
            r_ptr    <= '0;
            r_ld_err <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_ld_err <= w_ld_err_nxt;
        end
    end

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Directed bench for im_fetch_ctrl: stimulus queues expected IM writes and
// per-cycle observations; monitors on the falling edge pop and compare them.
module tb_im_fetch_ctrl;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   pc;
    logic [31:0]   instr;
    logic          cpu_stall, fetch_fault;
    logic          ld_start;
    logic [AW-1:0] ld_base;
    logic          ld_valid;
    logic [31:0]   ld_data;
    logic          ld_last;
    logic          ld_ready, ld_err;
    logic [AW-1:0] im_addr;
    logic          im_we;
    logic [31:0]   im_wdata;
    logic [31:0]   im_dout;

    logic [31:0] mem [0:(1<<AW)-1];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } obs_t;

    wr_t  wr_q[$];
    obs_t obs_q[$];

    localparam int O_INSTR = 0, O_STALL = 1, O_FAULT = 2, O_ERR = 3, O_RDY = 4;

    im_fetch_ctrl #(.AW(AW), .LOAD_ON_RESET(1'b1)) dut (
        .clk(clk), .rst(rst), .pc(pc), .instr(instr), .cpu_stall(cpu_stall),
        .fetch_fault(fetch_fault), .ld_start(ld_start), .ld_base(ld_base),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .ld_err(ld_err), .im_addr(im_addr), .im_we(im_we),
        .im_wdata(im_wdata), .im_dout(im_dout)
    );

    always #5 clk = ~clk;

    // behavioural IM: combinational read, synchronous write
    assign im_dout = mem[im_addr];
    always @(posedge clk) if (im_we) mem[im_addr] <= im_wdata;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            O_INSTR: return instr;
            O_STALL: return {31'b0, cpu_stall};
            O_FAULT: return {31'b0, fetch_fault};
            O_ERR:   return {31'b0, ld_err};
            default: return {31'b0, ld_ready};
        endcase
    endfunction

    // write monitor: every im_we must match the oldest expected write
    always @(negedge clk) begin
        if (im_we) begin
            n_tests++;
            if (wr_q.size() == 0) begin
                n_fail++;
                $display("FAIL wr_unexpected: got addr=%03h data=%08h, none expected", im_addr, im_wdata);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                if (im_addr !== e.addr || im_wdata !== e.data) begin
                    n_fail++;
                    $display("FAIL wr: got addr=%03h data=%08h, expected addr=%03h data=%08h",
                             im_addr, im_wdata, e.addr, e.data);
                end
            end
        end
    end

    // observation monitor: drains everything the stimulus queued for this cycle
    always @(negedge clk) begin
        while (obs_q.size() != 0) begin
            obs_t o;
            logic [31:0] got;
            o   = obs_q.pop_front();
            got = observe(o.sel);
            n_tests++;
            if (got !== o.val) begin
                n_fail++;
                $display("FAIL %s: got %08h, expected %08h", o.name, got, o.val);
            end
        end
    end

    task automatic expect_obs(input string name, input int sel, input logic [31:0] val);
        obs_t o;
        o.name = name; o.sel = sel; o.val = val;
        obs_q.push_back(o);
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a; w.data = d;
        wr_q.push_back(w);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = 32'hDEAD_BEEF;
    endtask

    task automatic send(input logic [31:0] d, input logic last, input logic [AW-1:0] a);
        ld_valid = 1'b1; ld_data = d; ld_last = last;
        expect_wr(a, d);
        expect_obs("load_stall", O_STALL, 1);
        expect_obs("load_ready", O_RDY, 1);
        step();
        idle();
    endtask

    task automatic fetch(input string name, input logic [31:0] p, input logic [31:0] exp);
        pc = p;
        expect_obs(name, O_INSTR, exp);
        expect_obs({name, "_stall"}, O_STALL, 0);
        step();
    endtask

    task automatic start_load(input logic [AW-1:0] base);
        ld_start = 1'b1; ld_base = base;
        step();
        idle();
    endtask

    initial begin
        for (int i = 0; i < (1<<AW); i++) mem[i] = 32'h0;
        rst = 1'b1; pc = 32'h0; ld_base = '0;
        idle();
        step();
        expect_obs("rst_stall", O_STALL, 1);
        expect_obs("rst_ready", O_RDY, 0);
        expect_obs("rst_instr", O_INSTR, 0);
        expect_obs("rst_fault", O_FAULT, 0);
        expect_obs("rst_err", O_ERR, 0);
        step();
        rst = 1'b0;

        // 1: boot load of four words, then fetch
        send(32'h2008_0005, 1'b0, 10'h000);
        send(32'h2009_0003, 1'b0, 10'h001);
        send(32'h0109_5020, 1'b0, 10'h002);
        send(32'h0800_0003, 1'b1, 10'h003);
        fetch("t1_pc8", 32'h8, 32'h0109_5020);
        fetch("t1_pc0", 32'h0, 32'h2008_0005);

        // 2: reload at 0x100; instruction in the ld_start cycle still delivered
        pc = 32'h4; ld_start = 1'b1; ld_base = 10'h100;
        expect_obs("t2_start_instr", O_INSTR, 32'h2009_0003);
        expect_obs("t2_start_stall", O_STALL, 0);
        step();
        idle();
        send(32'hAAAA_0001, 1'b0, 10'h100);
        send(32'hAAAA_0002, 1'b1, 10'h101);
        fetch("t2_pc404", 32'h404, 32'hAAAA_0002);

        // 3: valid gaps hold the pointer
        start_load(10'h200);
        send(32'hC0C0_0001, 1'b0, 10'h200);
        expect_obs("t3_gap_stall", O_STALL, 1);
        step();
        ld_data = 32'h1234_5678;
        step();
        send(32'hC0C0_0002, 1'b1, 10'h201);
        fetch("t3_pc800", 32'h800, 32'hC0C0_0001);
        fetch("t3_pc804", 32'h804, 32'hC0C0_0002);

        // 4: wrap past the top of IM
        start_load(10'h3FF);
        expect_obs("t4_err_pre", O_ERR, 0);
        send(32'hEEEE_0001, 1'b0, 10'h3FF);
        expect_obs("t4_err_set", O_ERR, 1);
        send(32'hEEEE_0002, 1'b1, 10'h000);
        expect_obs("t4_err_run", O_ERR, 1);
        fetch("t4_pc0", 32'h0, 32'hEEEE_0002);
        fetch("t4_pcffc", 32'hFFC, 32'hEEEE_0001);

        // 5: misaligned PC
        pc = 32'h6;
        expect_obs("t5a_instr", O_INSTR, 0);
        expect_obs("t5a_stall", O_STALL, 1);
        expect_obs("t5a_fault_now", O_FAULT, 0);
        step();
        pc = 32'h0;
        expect_obs("t5a_fault", O_FAULT, 1);
        expect_obs("t5a_instr_f", O_INSTR, 0);
        expect_obs("t5a_stall_f", O_STALL, 1);
        step();
        expect_obs("t5a_fault_hold", O_FAULT, 1);
        expect_obs("t5a_err_hold", O_ERR, 1);
        ld_start = 1'b1; ld_base = 10'h010;
        step();
        idle();
        expect_obs("t5a_fault_clr", O_FAULT, 0);
        expect_obs("t5a_err_clr", O_ERR, 0);
        send(32'h5555_0010, 1'b1, 10'h010);
        fetch("t5_pc40", 32'h40, 32'h5555_0010);
        // out-of-range PC
        pc = 32'h1000;
        expect_obs("t5b_instr", O_INSTR, 0);
        expect_obs("t5b_stall", O_STALL, 1);
        step();
        pc = 32'h0;
        expect_obs("t5b_fault", O_FAULT, 1);
        step();

        // 6: reset in the middle of a load
        ld_start = 1'b1; ld_base = 10'h020;
        step();
        idle();
        send(32'h6666_0001, 1'b0, 10'h020);
        rst = 1'b1; ld_valid = 1'b1; ld_data = 32'h6666_0002;
        expect_obs("t6_rst_ready", O_RDY, 0);
        step();
        rst = 1'b0;
        idle();
        expect_obs("t6_stall", O_STALL, 1);
        expect_obs("t6_ready", O_RDY, 1);
        expect_obs("t6_err", O_ERR, 0);
        expect_obs("t6_fault", O_FAULT, 0);
        step();
        send(32'h6666_0003, 1'b1, 10'h000);
        fetch("t6_pc80", 32'h80, 32'h6666_0001);
        fetch("t6_pc84", 32'h84, 32'h0);
        fetch("t6_pc0", 32'h0, 32'h6666_0003);

        step();
        n_tests++;
        if (wr_q.size() != 0 || obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d writes and %0d checks pending, expected 0", wr_q.size(), obs_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/im_fetch_ctrl.md
Name: im_fetch_ctrl

Overview:
- Controller in front of the 4 KiB instruction memory (1024 x 32-bit words, word-addressed by bits [11:2]).
- Shares the single memory port between two requesters:
  - a program loader, which streams words in after reset or on demand;
  - the CPU fetch path, which presents the PC and receives the instruction.
- Sequences LOAD/RUN/FAULT modes and stalls the CPU while the memory is not holding a valid program.

Parameters:
- AW, 10, IM word-address width (IM depth = 2^AW words).
- LOAD_ON_RESET, 1, 1: enter LOAD after reset; 0: enter RUN directly, using the preinitialised image.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- pc  in  32  CPU program counter.
- instr  out  32  instruction to decode; 32'h0000_0000 (nop) whenever cpu_stall=1.
- cpu_stall  out  1  holds the PC register and inhibits all CPU state writes.
- fetch_fault  out  1  sticky; set on misaligned or out-of-range PC.
- ld_start  in  1  request a (re)load; sampled in RUN and FAULT.
- ld_base  in  AW  first word address of a load, captured with ld_start.
- ld_valid  in  1  loader word valid.
- ld_data  in  32  loader word.
- ld_last  in  1  marks the final word; qualified by ld_valid.
- ld_ready  out  1  controller accepts a word this cycle.
- ld_err  out  1  sticky; load wrapped past the top of IM.
- im_addr  out  AW  to IM address [11:2].
- im_we  out  1  IM synchronous write enable.
- im_wdata  out  32  IM write data.
- im_dout  in  32  IM combinational read data.

Behaviour:
- Reset values:
  - state = LOAD if LOAD_ON_RESET, else RUN.
  - Load pointer = 0.
  - cpu_stall = 1 in LOAD, 0 in RUN.
  - instr = 0, ld_ready = 0, im_we = 0, im_addr = 0, im_wdata = 0.
  - fetch_fault = 0, ld_err = 0.
- rst mid-load aborts the load immediately. Already-written words stay in IM; the pointer and flags clear.
- State LOAD:
  - cpu_stall = 1, ld_ready = 1.
  - im_addr = load pointer; im_we = ld_valid; im_wdata = ld_data. The write completes at the same clock edge (zero added latency).
  - Handshake: a transfer occurs when ld_valid & ld_ready; the pointer then increments by 1.
  - On transfer with ld_last = 1 → RUN next cycle; cpu_stall deasserts that cycle.
  - Wrap: a transfer at pointer = 2^AW-1 without ld_last sets ld_err and wraps the pointer to 0. The load continues.
  - ld_start is ignored in LOAD.
- State RUN:
  - cpu_stall = 0, ld_ready = 0, im_we = 0.
  - im_addr = pc[AW+1:2]; instr = im_dout. Combinational: the instruction appears in the same cycle as the PC.
  - Fault check: pc[1:0] != 0 or pc[31:AW+2] != 0 → FAULT at the next edge. During that cycle instr is already forced to 0 and cpu_stall = 1, so no bad instruction retires.
  - ld_start = 1 → LOAD next cycle; pointer := ld_base; ld_err cleared. The instruction in the ld_start cycle still completes.
  - ld_start has priority over a simultaneous fault condition. fetch_fault stays 0 in that case.
- State FAULT:
  - cpu_stall = 1, instr = 0, fetch_fault = 1.
  - Leaves only via ld_start (→ LOAD, fetch_fault cleared) or rst.
- Word counter is AW bits and wraps modulo 2^AW.
- No write ever occurs outside LOAD.
- ld_data is ignored when ld_valid = 0.

Test Plan:
1. Reset, LOAD_ON_RESET=1; stream 4 words 0x20080005, 0x20090003, 0x01095020, 0x08000003 with ld_last on the 4th → 4 cycles of im_we at addrs 0..3. Then RUN with cpu_stall = 0; pc = 0x8 gives instr = 0x01095020 in the same cycle.
2. In RUN at pc = 0x4, pulse ld_start with ld_base = 0x100; send 2 words, the 2nd with ld_last → RUN stays for the ld_start cycle. Then LOAD writes addrs 0x100 and 0x101, then RUN. Read pc = 0x404 → the 2nd loaded word.
3. ld_valid gaps: valid pattern 1,0,0,1(last) → exactly 2 writes at consecutive addrs; pointer holds during the gaps.
4. Wrap: ld_base = 0x3FF; send 2 words, the 2nd with ld_last → writes at 0x3FF then 0x000; ld_err = 1 and stays set in RUN until the next ld_start.
5. Faults:
   - pc = 0x00000006 in RUN → instr = 0 and cpu_stall = 1 the same cycle; fetch_fault = 1 next cycle and persists.
   - Separately, pc = 0x00001000 → same response.
   - ld_start in FAULT → LOAD, fetch_fault = 0.
6. Assert rst on the 2nd of 3 load words → next cycle: state LOAD, pointer 0, ld_err = 0; the already-written word 0 is still readable after a subsequent load of word 0 only.
